// File: rtl/rsa_pkg.sv
// Shared definitions for the modular exponentiation core: ladder state codes,
// default operand width and the exponent bit-length helper.
package rsa_pkg;

  localparam int RSA_DEFAULT_W = 256;
  localparam int RSA_MAX_W     = 4096;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_PREP   = 3'd1;
  localparam logic [2:0] S_LAUNCH = 3'd2;
  localparam logic [2:0] S_WAIT   = 3'd3;
  localparam logic [2:0] S_DONE   = 3'd4;

  // Index of the highest set bit, or -1 for an all-zero vector
  function automatic int msb_index(input logic [RSA_MAX_W-1:0] v);
    int idx;
    idx = -1;
    for (int i = 0; i < RSA_MAX_W; i++) begin
      if (v[i]) begin
        idx = i;
      end else begin
        idx = idx;
      end
    end
    return idx;
  endfunction

endpackage

// File: rtl/rsa_mont_mul.sv
// Radix-2 Montgomery multiplier: o_m = a*b*2^-W mod n, result W+2 cycles after i_start.
module rsa_mont_mul
  import rsa_pkg::*;
#(
  parameter int W  = RSA_DEFAULT_W,
  parameter int CW = $clog2(W + 2)
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_abort,
  input  logic         i_start,
  input  logic [W-1:0] i_a,
  input  logic [W-1:0] i_b,
  input  logic [W-1:0] i_n,
  output logic [W-1:0] o_m,
  output logic         o_done
);

  localparam logic [1:0]    P_IDLE   = 2'd0;
  localparam logic [1:0]    P_RUN    = 2'd1;
  localparam logic [1:0]    P_SUB    = 2'd2;
  localparam logic [CW-1:0] CNT_LAST = CW'(W - 1);
  localparam logic [CW-1:0] CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};

  logic [1:0]    phase_r;
  logic [W-1:0]  a_sh_r;
  logic [W-1:0]  b_r;
  logic [W-1:0]  n_r;
  logic [W+1:0]  acc_r;
  logic [CW-1:0] cnt_r;
  logic [W-1:0]  m_r;
  logic          done_r;

  logic [W+1:0]  acc_add_s;
  logic [W+1:0]  n_term_s;
  logic [W+1:0]  acc_nxt_s;

  // One shift-add-reduce step; acc stays below 2n so W+2 bits never overflow
  always_comb begin
    acc_add_s = acc_r;
    n_term_s  = {(W+2){1'b0}};
    if (a_sh_r[0]) begin
      acc_add_s = acc_r + {2'b00, b_r};
    end else begin
      acc_add_s = acc_r;
    end
    if (acc_add_s[0]) begin
      n_term_s = {2'b00, n_r};
    end else begin
      n_term_s = {(W+2){1'b0}};
    end
    acc_nxt_s = (acc_add_s + n_term_s) >> 1;
  end

  // Iteration sequencer, final conditional subtract and done pulse
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      phase_r <= P_IDLE;
      a_sh_r  <= {W{1'b0}};
      b_r     <= {W{1'b0}};
      n_r     <= {W{1'b0}};
      acc_r   <= {(W+2){1'b0}};
      cnt_r   <= {CW{1'b0}};
      m_r     <= {W{1'b0}};
      done_r  <= 1'b0;
    end else if (i_abort) begin
      phase_r <= P_IDLE;
      done_r  <= 1'b0;
    end else begin
      case (phase_r)
        P_IDLE: begin
          done_r <= 1'b0;
          if (i_start) begin
            a_sh_r  <= i_a;
            b_r     <= i_b;
            n_r     <= i_n;
            acc_r   <= {(W+2){1'b0}};
            cnt_r   <= {CW{1'b0}};
            phase_r <= P_RUN;
          end
        end
        P_RUN: begin
          acc_r  <= acc_nxt_s;
          a_sh_r <= {1'b0, a_sh_r[W-1:1]};
          cnt_r  <= cnt_r + CNT_ONE;
          if (cnt_r == CNT_LAST) begin
            phase_r <= P_SUB;
          end
        end
        P_SUB: begin
          if (acc_r >= {2'b00, n_r}) begin
            m_r <= W'(acc_r - {2'b00, n_r});
          end else begin
            m_r <= W'(acc_r);
          end
          done_r  <= 1'b1;
          phase_r <= P_IDLE;
        end
        default: begin
          phase_r <= P_IDLE;
          done_r  <= 1'b0;
        end
      endcase
    end
  end

  assign o_m    = m_r;
  assign o_done = done_r;

endmodule

// File: rtl/rsa_modexp_core.sv
// Computes o_a_pow_d = i_a^i_d mod i_n with a right-to-left ladder driving a
// Montgomery square unit and a Montgomery multiply unit in parallel.
module rsa_modexp_core
  import rsa_pkg::*;
#(
  parameter int W  = RSA_DEFAULT_W,
  parameter int CW = $clog2(W + 2)
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_start,
  input  logic         i_abort,
  input  logic [W-1:0] i_a,
  input  logic [W-1:0] i_d,
  input  logic [W-1:0] i_n,
  output logic [W-1:0] o_a_pow_d,
  output logic         o_busy,
  output logic         o_finished
);

  localparam logic [W-1:0]  ONE_W     = {{(W-1){1'b0}}, 1'b1};
  localparam logic [CW-1:0] ONE_CW    = {{(CW-1){1'b0}}, 1'b1};
  localparam logic [CW-1:0] PREP_LAST = CW'(W - 1);

  logic [2:0]    state_r;
  logic [2:0]    state_step_s;
  logic [2:0]    state_nxt_s;
  logic [W-1:0]  t_r;
  logic [W-1:0]  m_r;
  logic [W-1:0]  n_r;
  logic [W-1:0]  d_sh_r;
  logic [CW-1:0] cnt_r;
  logic [CW-1:0] j_r;
  logic [CW-1:0] l_r;
  logic          sq_flag_r;
  logic          mul_flag_r;
  logic [W-1:0]  sq_res_r;
  logic [W-1:0]  mul_res_r;
  logic [W-1:0]  a_pow_d_r;
  logic          busy_r;
  logic          finished_r;

  logic [CW-1:0] l_in_s;
  logic          core_abort_s;
  logic          sq_start_s;
  logic          mul_start_s;
  logic [W-1:0]  sq_m_s;
  logic [W-1:0]  mul_m_s;
  logic          sq_done_s;
  logic          mul_done_s;
  logic          sq_ok_s;
  logic          mul_ok_s;
  logic          step_s;
  logic [W-1:0]  sq_val_s;
  logic [W-1:0]  mul_val_s;
  logic [W-1:0]  m_nxt_s;
  logic [W+1:0]  t_x2_s;
  logic [W-1:0]  t_dbl_s;

  // Ladder datapath: unit handshakes, pre-scaling step and next accumulator value
  always_comb begin
    l_in_s       = CW'(msb_index({{(RSA_MAX_W-W){1'b0}}, i_d}) + 1);
    core_abort_s = i_abort && (state_r != S_IDLE);
    sq_start_s   = (state_r == S_LAUNCH);
    mul_start_s  = (state_r == S_LAUNCH) && d_sh_r[0];
    sq_ok_s      = sq_flag_r || sq_done_s;
    mul_ok_s     = mul_flag_r || mul_done_s;
    step_s       = (state_r == S_WAIT) && sq_ok_s && mul_ok_s;
    sq_val_s     = sq_done_s ? sq_m_s : sq_res_r;
    mul_val_s    = mul_done_s ? mul_m_s : mul_res_r;
    t_x2_s       = {1'b0, t_r, 1'b0};
    t_dbl_s      = W'(t_x2_s);
    if (t_x2_s >= {2'b00, n_r}) begin
      t_dbl_s = W'(t_x2_s - {2'b00, n_r});
    end else begin
      t_dbl_s = W'(t_x2_s);
    end
    m_nxt_s = m_r;
    if (state_r == S_IDLE) begin
      m_nxt_s = ONE_W;
    end else if (step_s && d_sh_r[0]) begin
      m_nxt_s = mul_val_s;
    end else begin
      m_nxt_s = m_r;
    end
  end

  // Next-state decode; abort overrides everything outside S_IDLE
  always_comb begin
    state_step_s = state_r;
    case (state_r)
      S_IDLE: begin
        if (i_start) begin
          state_step_s = (i_d == {W{1'b0}}) ? S_DONE : S_PREP;
        end else begin
          state_step_s = S_IDLE;
        end
      end
      S_PREP: begin
        if (cnt_r == PREP_LAST) begin
          state_step_s = S_LAUNCH;
        end else begin
          state_step_s = S_PREP;
        end
      end
      S_LAUNCH: state_step_s = S_WAIT;
      S_WAIT: begin
        if (step_s) begin
          state_step_s = ((j_r + ONE_CW) < l_r) ? S_LAUNCH : S_DONE;
        end else begin
          state_step_s = S_WAIT;
        end
      end
      S_DONE:  state_step_s = S_IDLE;
      default: state_step_s = S_IDLE;
    endcase
    state_nxt_s = core_abort_s ? S_IDLE : state_step_s;
  end

  // State, operand, ladder and output registers
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_r    <= S_IDLE;
      t_r        <= {W{1'b0}};
      m_r        <= {W{1'b0}};
      n_r        <= {W{1'b0}};
      d_sh_r     <= {W{1'b0}};
      cnt_r      <= {CW{1'b0}};
      j_r        <= {CW{1'b0}};
      l_r        <= {CW{1'b0}};
      sq_flag_r  <= 1'b0;
      mul_flag_r <= 1'b0;
      sq_res_r   <= {W{1'b0}};
      mul_res_r  <= {W{1'b0}};
      a_pow_d_r  <= {W{1'b0}};
      busy_r     <= 1'b0;
      finished_r <= 1'b0;
    end else begin
      state_r    <= state_nxt_s;
      busy_r     <= (state_nxt_s != S_IDLE);
      finished_r <= (state_nxt_s == S_DONE);
      if (state_nxt_s == S_DONE) begin
        a_pow_d_r <= m_nxt_s;
      end
      case (state_r)
        S_IDLE: begin
          if (i_start) begin
            t_r    <= i_a;
            n_r    <= i_n;
            d_sh_r <= i_d;
            l_r    <= l_in_s;
            j_r    <= {CW{1'b0}};
            cnt_r  <= {CW{1'b0}};
            m_r    <= ONE_W;
          end
        end
        S_PREP: begin
          t_r   <= t_dbl_s;
          cnt_r <= cnt_r + ONE_CW;
        end
        S_WAIT: begin
          if (step_s) begin
            t_r    <= sq_val_s;
            m_r    <= m_nxt_s;
            j_r    <= j_r + ONE_CW;
            d_sh_r <= {1'b0, d_sh_r[W-1:1]};
          end
        end
        default: begin
          t_r <= t_r;
        end
      endcase
      // Sticky per-unit completion; a zero exponent bit needs no multiply
      if (core_abort_s || step_s) begin
        sq_flag_r  <= 1'b0;
        mul_flag_r <= 1'b0;
      end else begin
        if (sq_done_s) begin
          sq_flag_r <= 1'b1;
          sq_res_r  <= sq_m_s;
        end
        if (mul_done_s) begin
          mul_flag_r <= 1'b1;
          mul_res_r  <= mul_m_s;
        end
        if ((state_r == S_LAUNCH) && !d_sh_r[0]) begin
          mul_flag_r <= 1'b1;
        end
      end
    end
  end

  rsa_mont_mul #(.W(W), .CW(CW)) u_square (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_abort (core_abort_s),
    .i_start (sq_start_s),
    .i_a     (t_r),
    .i_b     (t_r),
    .i_n     (n_r),
    .o_m     (sq_m_s),
    .o_done  (sq_done_s)
  );

  rsa_mont_mul #(.W(W), .CW(CW)) u_multiply (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_abort (core_abort_s),
    .i_start (mul_start_s),
    .i_a     (m_r),
    .i_b     (t_r),
    .i_n     (n_r),
    .o_m     (mul_m_s),
    .o_done  (mul_done_s)
  );

  assign o_a_pow_d  = a_pow_d_r;
  assign o_busy     = busy_r;
  assign o_finished = finished_r;

endmodule

// File: tb/tb_rsa_modexp_core.sv
// Self-checking bench for rsa_modexp_core at W=8: directed plan vectors plus
// randomized operands compared against a plain-arithmetic reference.
module tb_rsa_modexp_core;

  localparam int W = 8;

  logic         i_clk = 1'b0;
  logic         i_rst;
  logic         i_start;
  logic         i_abort;
  logic [W-1:0] i_a;
  logic [W-1:0] i_d;
  logic [W-1:0] i_n;
  logic [W-1:0] o_a_pow_d;
  logic         o_busy;
  logic         o_finished;

  int tests = 0;
  int fails = 0;

  logic [W-1:0] res;
  logic [W-1:0] prev;
  logic [W-1:0] ra;
  logic [W-1:0] rd;
  logic [W-1:0] rn;
  int           lat;
  int           fin_cnt;
  int           busy_cnt;
  int           nz_cnt;
  bit           busy_ok;
  bit           post_ok;
  bit           poke;

  rsa_modexp_core #(.W(W)) dut (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_start    (i_start),
    .i_abort    (i_abort),
    .i_a        (i_a),
    .i_d        (i_d),
    .i_n        (i_n),
    .o_a_pow_d  (o_a_pow_d),
    .o_busy     (o_busy),
    .o_finished (o_finished)
  );

  always #5 i_clk = ~i_clk;

  // a^d mod n by repeated multiplication
  function automatic logic [W-1:0] ref_pow(input logic [W-1:0] a, input logic [W-1:0] d,
                                           input logic [W-1:0] n);
    longint unsigned r;
    longint unsigned base;
    longint unsigned md;
    r    = 64'd1;
    base = 64'(a);
    md   = 64'(n);
    for (int k = 0; k < int'(d); k++) r = (r * base) % md;
    return W'(r % md);
  endfunction

  // Cycle number of o_finished, counting the start cycle as 1
  function automatic int ref_lat(input logic [W-1:0] d);
    int bits;
    bits = 0;
    for (int i = 0; i < W; i++) if (d[i]) bits = i + 1;
    return (d == {W{1'b0}}) ? 2 : (2 + W + bits * (W + 3));
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  // Start one operation, scramble the inputs, optionally poke i_start while busy,
  // and return the result, its cycle number and the state one cycle later
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] d, input logic [W-1:0] n,
                        input bit do_poke, output logic [W-1:0] r, output int l,
                        output bit b_ok, output bit p_ok);
    int cyc;
    i_a = a; i_d = d; i_n = n; i_start = 1'b1;
    tick();
    i_start = 1'b0;
    i_a = W'($urandom); i_d = W'($urandom); i_n = W'($urandom);
    cyc = 2; l = -1; r = {W{1'b0}}; b_ok = 1'b1;
    while (cyc < 1000 && l < 0) begin
      if (o_finished) begin
        l = cyc;
        r = o_a_pow_d;
      end
      if (!o_busy) b_ok = 1'b0;
      i_start = do_poke && (cyc == 4);
      tick();
      cyc++;
    end
    i_start = 1'b0;
    p_ok = !o_finished && !o_busy && (o_a_pow_d === r);
  endtask

  initial begin
    i_rst = 1'b1; i_start = 1'b0; i_abort = 1'b0;
    i_a = {W{1'b0}}; i_d = {W{1'b0}}; i_n = {W{1'b0}};
    tick(); tick();
    check("reset_result", 32'(o_a_pow_d), 32'd0);
    check("reset_busy", 32'(o_busy), 32'd0);
    check("reset_finished", 32'(o_finished), 32'd0);
    i_rst = 1'b0;
    tick();

    run_op(8'd5, 8'd3, 8'd13, 1'b0, res, lat, busy_ok, post_ok);
    check("p1_result", 32'(res), 32'd8);
    check("p1_latency", 32'(lat), 32'd32);
    check("p1_busy", 32'(busy_ok), 32'd1);
    check("p1_post", 32'(post_ok), 32'd1);

    run_op(8'd2, 8'd10, 8'd11, 1'b1, res, lat, busy_ok, post_ok);
    check("p2_result", 32'(res), 32'd1);
    check("p2_latency", 32'(lat), 32'd54);
    check("p2_post", 32'(post_ok), 32'd1);

    run_op(8'd7, 8'd0, 8'd13, 1'b0, res, lat, busy_ok, post_ok);
    check("d0_result", 32'(res), 32'd1);
    check("d0_latency", 32'(lat), 32'd2);
    check("d0_post", 32'(post_ok), 32'd1);

    // Abort in the fifth wait cycle of the first ladder bit
    prev = o_a_pow_d;
    i_a = 8'd5; i_d = 8'd3; i_n = 8'd13; i_start = 1'b1;
    tick();
    i_start = 1'b0;
    repeat (13) tick();
    i_abort = 1'b1;
    tick();
    i_abort = 1'b0;
    check("abort_busy", 32'(o_busy), 32'd0);
    check("abort_finished", 32'(o_finished), 32'd0);
    check("abort_result_held", 32'(o_a_pow_d), 32'(prev));
    fin_cnt = 0; busy_cnt = 0;
    repeat (40) begin
      if (o_finished) fin_cnt++;
      if (o_busy) busy_cnt++;
      tick();
    end
    check("abort_no_finish", 32'(fin_cnt), 32'd0);
    check("abort_idle", 32'(busy_cnt), 32'd0);
    run_op(8'd5, 8'd3, 8'd13, 1'b0, res, lat, busy_ok, post_ok);
    check("restart_result", 32'(res), 32'd8);
    check("restart_latency", 32'(lat), 32'd32);

    // Reset in the middle of pre-scaling with a start pulse issued while busy
    i_a = 8'd7; i_d = 8'd200; i_n = 8'd221; i_start = 1'b1;
    tick();
    i_start = 1'b0;
    tick();
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
    i_rst = 1'b1;
    tick();
    i_rst = 1'b0;
    check("midrst_result", 32'(o_a_pow_d), 32'd0);
    check("midrst_busy", 32'(o_busy), 32'd0);
    check("midrst_finished", 32'(o_finished), 32'd0);
    fin_cnt = 0; busy_cnt = 0; nz_cnt = 0;
    repeat (60) begin
      if (o_finished) fin_cnt++;
      if (o_busy) busy_cnt++;
      if (o_a_pow_d !== {W{1'b0}}) nz_cnt++;
      tick();
    end
    check("midrst_no_finish", 32'(fin_cnt), 32'd0);
    check("midrst_idle", 32'(busy_cnt + nz_cnt), 32'd0);

    // Back-to-back randomized operations against the reference
    for (int t = 0; t < 24; t++) begin
      rn = W'($urandom_range(1, 127) * 2 + 1);
      ra = W'($urandom_range(0, int'(rn) - 1));
      if (t % 6 == 0)      rd = {W{1'b0}};
      else if (t == 1)     rd = 8'd1;
      else if (t == 2)     rd = 8'd255;
      else if (t == 3)     rd = 8'd128;
      else                 rd = W'($urandom);
      poke = 1'($urandom_range(0, 1));
      run_op(ra, rd, rn, poke, res, lat, busy_ok, post_ok);
      check($sformatf("rnd%0d_result a=%0d d=%0d n=%0d", t, ra, rd, rn), 32'(res),
            32'(ref_pow(ra, rd, rn)));
      check($sformatf("rnd%0d_latency", t), 32'(lat), 32'(ref_lat(rd)));
      check($sformatf("rnd%0d_busy", t), 32'(busy_ok), 32'd1);
      check($sformatf("rnd%0d_post", t), 32'(post_ok), 32'd1);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/rsa_modexp_core.md
Name: rsa_modexp_core

Overview:
- Parametrised successor to the fixed 256-bit RSA decryption core. Computes o_a_pow_d = i_a^i_d mod i_n using a Montgomery ladder: right-to-left binary exponentiation with parallel square and multiply units.
- Generalised to any operand width W.
- Adds over the previous generation: early termination at the exponent MSB, a synchronous abort, a busy flag, and a defined d=0 result.
- Sits between the wrapper's receive/transmit FSM and the key registers.

Parameters:
- W, 256, operand width in bits for a, d and N.
- CW, $clog2(W+2), width of the internal iteration and bit counters.

Ports:
- i_clk  input  1  clock, rising edge.
- i_rst  input  1  synchronous, active-high reset.
- i_start  input  1  one-cycle start pulse; sampled only in S_IDLE.
- i_abort  input  1  synchronous abort; returns the block to S_IDLE.
- i_a  input  W  base (cipher text); must satisfy i_a < i_n.
- i_d  input  W  exponent (private key).
- i_n  input  W  modulus; must be odd and > 1.
- o_a_pow_d  output  W  result; held stable from o_finished until the next accepted start.
- o_busy  output  1  high from the cycle after an accepted start until the o_finished cycle (inclusive) or an abort.
- o_finished  output  1  one-cycle pulse when o_a_pow_d is valid.

Behaviour:
- Reset: i_rst sampled high on a rising edge forces the following state on the next edge:
  - state = S_IDLE
  - o_a_pow_d = 0, o_busy = 0, o_finished = 0
  - all counters and operand registers cleared
  - sub-module start pulses deasserted
  - Reset mid-operation discards all work and produces no o_finished.
- S_IDLE:
  - On i_start=1, latch i_a, i_d and i_n into registers, compute L = (index of MSB set in i_d) + 1, and set bit index j = 0.
  - If i_d == 0: go to S_DONE with m = 1.
  - Otherwise: go to S_PREP with m = 1.
- S_PREP:
  - Computes t = a * 2^W mod N by W iterations of "t = 2t; if t >= N then t -= N", starting from t = a.
  - One iteration per cycle, so W cycles. Then go to S_LAUNCH.
- S_LAUNCH (1 cycle):
  - Pulse start on the square unit with operands (t, t).
  - If d[j] == 1, also pulse start on the multiply unit with operands (m, t); otherwise mark the multiply unit as done.
  - Go to S_WAIT.
- S_WAIT:
  - Capture each unit's result on its o_done pulse. A done flag per unit is sticky until consumed.
  - When both flags are set (simultaneous o_done is legal), do the following in the same edge:
    - t <= square result
    - m <= multiply result, if bit j was 1
    - j <= j + 1
    - clear both flags
  - Then go to S_LAUNCH if j+1 < L, else S_DONE.
- S_DONE (1 cycle):
  - o_a_pow_d <= m, except that N == 1 is out of contract and undefined.
  - o_finished = 1 for this cycle only; o_busy drops the following cycle.
  - Go to S_IDLE.
- Domain rule: m stays in the normal domain, because mont(m, a*2^W) = m*a mod N. No final conversion is needed. d == 0 yields 1.
- Latency from the start edge to o_finished, exact:
  - d ≠ 0: 1 + W + L*(1 + (W+2)) + 1 cycles.
  - d == 0: 2 cycles.
- Abort: i_abort=1 in any state other than S_IDLE returns the block to S_IDLE on the next edge.
  - o_busy drops, there is no o_finished pulse, and o_a_pow_d keeps its previous value.
  - The sub-module done pulse of an aborted operation is ignored; each sub-module is reset through its own abort input.
- i_start while busy: ignored. i_start and i_abort together in S_IDLE: the start is accepted.
- Arithmetic widths: the PREP and Montgomery accumulators are W+2 bits to avoid overflow; results are truncated to W bits only after the final conditional subtraction.

Decomposition:
- Package rsa_pkg:
  - state enum: S_IDLE, S_PREP, S_LAUNCH, S_WAIT, S_DONE.
  - localparam default width 256.
  - function msb_index for computing L.
- Sub-module rsa_mont_mul #(W), instantiated twice (square and multiply units):
  - Radix-2 Montgomery multiply: W iterations of "if a[i] then acc += b; if acc[0] then acc += N; acc >>= 1", followed by one conditional-subtract cycle.
  - Ports: i_clk, i_rst, i_abort, i_start, i_a, i_b, i_n, o_m, o_done.
  - Latency from i_start to o_done: exactly W+2 cycles.

Test Plan:
- W=8, a=5, d=3, N=13 -> o_a_pow_d = 8; o_finished pulses exactly 1+8+2*11+1 = 32 cycles after start; o_busy is high for the whole run.
- W=8, a=2, d=10, N=11 -> result 1; L=4, so latency = 1+8+4*11+1 = 54 cycles; the bit-0 = 0 path is exercised.
- W=256, lab golden vector (cipher text, private key and N from the lab test data) -> plain text matches the golden file. Back-to-back starts with no idle gap beyond S_IDLE: both results are correct.
- d=0, any a, N=13 -> o_a_pow_d = 1 two cycles after start; the sub-modules are never started.
- Abort in the 5th S_WAIT cycle of the W=8 run (a=5, d=3, N=13) -> no o_finished, o_busy low next cycle, o_a_pow_d unchanged. A restart with the same operands then yields 8 at 32 cycles.
- i_rst asserted mid-PREP, plus i_start pulses during busy -> all outputs 0 after the reset edge. Starts issued while busy produce no extra o_finished and do not change the operands.
